// File: rtl/trace_capture_ctrl.sv
// Trace capture controller: round-robin arbitration of requester trace words into a
// circular trace RAM, trigger-qualified post capture, and oldest-first debug readout.
module trace_capture_ctrl #(
  parameter int Fpay     = 32,
  parameter int NREQ     = 4,
  parameter int TB_AW    = 9,
  parameter int POST_LEN = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   trigger,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*Fpay-1:0]   din,
  output logic [NREQ-1:0]        gnt,
  output logic                   tb_wr,
  output logic [TB_AW-1:0]       tb_wr_addr,
  output logic [Fpay-1:0]        tb_din,
  output logic                   tb_rd,
  output logic [TB_AW-1:0]       tb_rd_addr,
  input  logic [Fpay-1:0]        tb_dout,
  input  logic                   rd_next,
  output logic [Fpay-1:0]        rd_data,
  output logic                   rd_valid,
  output logic [2:0]             state,
  output logic [TB_AW:0]         count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] POST  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] READ  = 3'd4;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TB_AW:0]   DEPTH_C   = {1'b1, {TB_AW{1'b0}}};
  localparam logic [TB_AW:0]   ONE_C     = {{TB_AW{1'b0}}, 1'b1};
  localparam logic [TB_AW-1:0] POST_LAST = TB_AW'(POST_LEN - 1);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    rr_next;
  logic             gnt_valid;
  logic [Fpay-1:0]  gnt_word;
  logic [TB_AW-1:0] wr_addr;
  logic [TB_AW-1:0] rd_addr;
  logic [TB_AW-1:0] rd_cur;
  logic [TB_AW-1:0] post_cnt;
  logic [TB_AW:0]   remaining;
  logic [Fpay-1:0]  rd_hold;
  logic             rd_ok;
  logic             capturing;

  assign capturing = (state == ARMED) || (state == POST);

  // Search starts at the round-robin pointer and takes the first asserted request.
  always_comb begin : arb
    logic [PW-1:0] j;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt       = '0;
    gnt_word  = '0;
    j         = '0;
    if (capturing) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        j = PW'((32'(rr_ptr) + k) % NREQ);
        if (!gnt_valid && req[j]) begin
          gnt_valid = 1'b1;
          gnt_idx   = j;
        end
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_valid && (gnt_idx == PW'(k))) begin
        gnt[k]   = 1'b1;
        gnt_word = din[k*Fpay +: Fpay];
      end
    end
  end

  assign rr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // First read out of DONE starts at the oldest word; later reads follow rd_addr.
  assign rd_ok  = rd_next && (((state == DONE) && (count != '0)) ||
                              ((state == READ) && (remaining != '0)));
  assign rd_cur = (state == DONE) ? wr_addr - count[TB_AW-1:0] : rd_addr;

  assign rd_data = rd_valid ? tb_dout : rd_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tb_wr      <= 1'b0;
      tb_wr_addr <= '0;
      tb_din     <= '0;
      tb_rd      <= 1'b0;
      tb_rd_addr <= '0;
      rd_valid   <= 1'b0;
      rd_hold    <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      count      <= '0;
      remaining  <= '0;
      rr_ptr     <= '0;
      post_cnt   <= '0;
    end else begin
      tb_wr    <= gnt_valid;
      tb_rd    <= rd_ok;
      rd_valid <= tb_rd;
      if (rd_valid) rd_hold <= tb_dout;

      if (gnt_valid) begin
        tb_din     <= gnt_word;
        tb_wr_addr <= wr_addr;
        wr_addr    <= wr_addr + 1'b1;
        rr_ptr     <= rr_next;
        if (count != DEPTH_C) count <= count + ONE_C;
      end

      if (rd_ok) begin
        tb_rd_addr <= rd_cur;
        rd_addr    <= rd_cur + 1'b1;
      end

      case (state)
        IDLE: begin
          if (arm) begin
            state   <= ARMED;
            wr_addr <= '0;
            count   <= '0;
          end
        end
        ARMED: begin
          if (trigger) begin
            state    <= POST;
            post_cnt <= '0;
          end
        end
        POST: begin
          if (gnt_valid) begin
            post_cnt <= post_cnt + 1'b1;
            if (post_cnt == POST_LAST) state <= DONE;
          end
        end
        DONE: begin
          if (rd_next) begin
            if (count == '0) begin
              state <= IDLE;
            end else begin
              remaining <= count - ONE_C;
              if (count == ONE_C) begin
                state <= IDLE;
                count <= '0;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          if (remaining == '0) begin
            state <= IDLE;
            count <= '0;
          end else if (rd_next) begin
            remaining <= remaining - ONE_C;
            if (remaining == ONE_C) begin
              state <= IDLE;
              count <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: directed + randomized capture/readout sequences checked
// against a queue-based model of the trace history and readout order.
module tb_trace_capture_ctrl;

  localparam int FP    = 16;
  localparam int NR    = 4;
  localparam int AW    = 4;
  localparam int PL    = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              arm;
  logic              trigger;
  logic [NR-1:0]     req;
  logic [NR*FP-1:0]  din;
  logic [NR-1:0]     gnt;
  logic              tb_wr;
  logic [AW-1:0]     tb_wr_addr;
  logic [FP-1:0]     tb_din;
  logic              tb_rd;
  logic [AW-1:0]     tb_rd_addr;
  logic [FP-1:0]     tb_dout;
  logic              rd_next;
  logic [FP-1:0]     rd_data;
  logic              rd_valid;
  logic [2:0]        state;
  logic [AW:0]       count;

  trace_capture_ctrl #(
    .Fpay    (FP),
    .NREQ    (NR),
    .TB_AW   (AW),
    .POST_LEN(PL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .trigger   (trigger),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .tb_wr     (tb_wr),
    .tb_wr_addr(tb_wr_addr),
    .tb_din    (tb_din),
    .tb_rd     (tb_rd),
    .tb_rd_addr(tb_rd_addr),
    .tb_dout   (tb_dout),
    .rd_next   (rd_next),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .state     (state),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Synchronous trace RAM: read data one cycle after tb_rd.
  logic [FP-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (tb_wr) mem[tb_wr_addr] <= tb_din;
    if (tb_rd) tb_dout <= mem[tb_rd_addr];
  end

  int tests = 0;
  int fails = 0;

  // Reference model: history queue of captured words, readout queue, spec-level state.
  int            mstate;
  logic [FP-1:0] hist[$];
  logic [FP-1:0] rdq[$];
  int            wtotal;
  int            rr;
  int            post;
  int            rd_ptr_m;
  logic          prev_rdv;
  logic [FP-1:0] prev_word;
  logic [FP-1:0] last_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mstate = 0;
    hist.delete();
    rdq.delete();
    wtotal = 0;
    rr = 0;
    post = 0;
    rd_ptr_m = 0;
    prev_rdv = 1'b0;
    prev_word = '0;
    last_rd = '0;
  endtask

  task automatic cycle(input logic a, input logic t, input logic [NR-1:0] r, input logic n);
    logic          gv;
    int            gi;
    logic          rdv;
    logic [FP-1:0] rword;
    logic [FP-1:0] wword;
    int            waddr;
    int            raddr;
    @(negedge clk);
    arm = a; trigger = t; req = r; rd_next = n;
    for (int i = 0; i < NR; i++) din[i*FP +: FP] = FP'($urandom);
    #1;
    gv = 1'b0; gi = 0;
    if (mstate == 1 || mstate == 2) begin
      for (int k = 0; k < NR; k++) begin
        if (!gv && r[(rr + k) % NR]) begin
          gv = 1'b1;
          gi = (rr + k) % NR;
        end
      end
    end
    chk("gnt", 64'(gnt), gv ? (64'd1 << gi) : 64'd0);

    wword = '0; waddr = 0; rdv = 1'b0; rword = '0; raddr = 0;
    if (gv) begin
      wword = din[gi*FP +: FP];
      waddr = wtotal % DEPTH;
      wtotal++;
      hist.push_back(wword);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      rr = (gi + 1) % NR;
    end
    case (mstate)
      0: if (a) begin mstate = 1; hist.delete(); wtotal = 0; end
      1: if (t) begin mstate = 2; post = 0; end
      2: if (gv) begin post++; if (post == PL) mstate = 3; end
      3: if (n) begin
           if (hist.size() == 0) mstate = 0;
           else begin
             rdq = hist;
             rd_ptr_m = ((wtotal - hist.size()) % DEPTH + DEPTH) % DEPTH;
             rdv = 1'b1;
           end
         end
      4: if (n && rdq.size() > 0) rdv = 1'b1;
      default: ;
    endcase
    if (rdv) begin
      rword = rdq.pop_front();
      raddr = rd_ptr_m;
      rd_ptr_m = (rd_ptr_m + 1) % DEPTH;
      if (rdq.size() == 0) begin mstate = 0; hist.delete(); end
      else mstate = 4;
    end

    @(posedge clk);
    #1;
    chk("tb_wr", 64'(tb_wr), 64'(gv));
    if (gv) begin
      chk("tb_din", 64'(tb_din), 64'(wword));
      chk("tb_wr_addr", 64'(tb_wr_addr), 64'(waddr));
    end
    chk("tb_rd", 64'(tb_rd), 64'(rdv));
    if (rdv) chk("tb_rd_addr", 64'(tb_rd_addr), 64'(raddr));
    chk("rd_valid", 64'(rd_valid), 64'(prev_rdv));
    if (prev_rdv) begin
      chk("rd_data", 64'(rd_data), 64'(prev_word));
      last_rd = prev_word;
    end else begin
      chk("rd_data_hold", 64'(rd_data), 64'(last_rd));
    end
    prev_rdv = rdv;
    prev_word = rword;
    chk("state", 64'(state), 64'(mstate));
    chk("count", 64'(count), 64'(hist.size()));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_tb_wr"}, 64'(tb_wr), 64'd0);
    chk({tag, "_tb_rd"}, 64'(tb_rd), 64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    req = '1; arm = 1'b0; trigger = 1'b0; rd_next = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    reset_checks("midrst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
  endtask

  task automatic run_to_done_and_read(input string tag);
    int guard;
    guard = 0;
    while (mstate != 3 && mstate != 0 && guard < 300) begin
      cycle(1'b0, 1'b1, NR'($urandom), 1'($urandom));
      guard++;
    end
    chk({tag, "_reach_done"}, 64'(guard < 300), 64'd1);
    guard = 0;
    while (mstate != 0 && guard < 300) begin
      cycle(1'($urandom), 1'b0, NR'($urandom), 1'($urandom));
      guard++;
    end
    chk({tag, "_reach_idle"}, 64'(guard < 300), 64'd1);
    cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; arm = 1'b0; trigger = 1'b0; req = '0; rd_next = 1'b0; din = '0;
    model_reset();
    #1;
    reset_checks("rst");
    chk("rst_tb_din", 64'(tb_din), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Trigger and rd_next in IDLE are ignored.
    cycle(1'b0, 1'b1, '0, 1'b1);

    // Full-request rotation, trigger coincident with a grant, 12 words total.
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, '1, 1'b0);
    cycle(1'b0, 1'b1, '1, 1'b0);
    for (int i = 0; i < PL; i++) cycle(1'b0, 1'b0, '1, 1'b0);
    chk("v1_state_done", 64'(state), 64'd3);
    chk("v1_count", 64'(count), 64'd12);
    cycle(1'b1, 1'b0, '1, 1'b0);
    cycle(1'b0, 1'b1, '1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    chk("v6_state_idle", 64'(state), 64'd0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // 40 single-requester words wrap the 16-deep history before the trigger.
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, NR'(1 << $urandom_range(0, NR-1)), 1'($urandom));
    cycle(1'b0, 1'b1, '0, 1'b0);
    cycle(1'b1, 1'b0, 4'b0010, 1'b1);
    for (int i = 0; i < PL - 1; i++) cycle(1'b0, 1'b0, 4'b1000, 1'b0);
    chk("v2_count_sat", 64'(count), 64'd16);
    cycle(1'b0, 1'b0, '1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);

    // Randomized capture/readout runs.
    for (int run = 0; run < 4; run++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < int'($urandom_range(3, 30)); i++)
        cycle(1'b0, 1'b0, NR'($urandom), 1'($urandom));
      run_to_done_and_read("rand");
    end

    // Reset in POST with requests active, then restart from address 0.
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '1, 1'b0);
    cycle(1'b0, 1'b1, '1, 1'b0);
    cycle(1'b0, 1'b0, '1, 1'b0);
    do_reset_mid();
    cycle(1'b0, 1'b0, '1, 1'b1);
    cycle(1'b1, 1'b0, '1, 1'b0);
    cycle(1'b0, 1'b0, 4'b0100, 1'b0);
    chk("v5_count_restart", 64'(count), 64'd1);
    run_to_done_and_read("v5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trace_capture_ctrl.md
TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 Parameter Fpay, default 32: trace word width in bits.
REQ-002 Parameter NREQ, default 4: number of trace requesters (tiles), range 2..8.
REQ-003 Parameter TB_AW, default 9: trace RAM address width; depth DEPTH = 2^TB_AW.
REQ-004 Parameter POST_LEN, default 64: words captured after trigger, range 1..DEPTH-1.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 arm  in  1  single-cycle pulse; starts a capture from IDLE.
REQ-008 trigger  in  1  level; qualifies end-of-capture while ARMED.
REQ-009 req  in  NREQ  per-requester trace-word-valid.
REQ-010 din  in  NREQ*Fpay  requester words; requester i occupies bits [i*Fpay +: Fpay].
REQ-011 gnt  out  NREQ  one-hot grant; a requester's word is consumed in the cycle gnt[i]=1.
REQ-012 tb_wr, tb_wr_addr, tb_din  out  1, TB_AW, Fpay  trace RAM write port.
REQ-013 tb_rd, tb_rd_addr  out  1, TB_AW  trace RAM read port; RAM returns data one cycle after tb_rd.
REQ-014 tb_dout  in  Fpay  trace RAM read data.
REQ-015 rd_next  in  1  debug-side (JTAG) request for next captured word.
REQ-016 rd_data, rd_valid  out  Fpay, 1  readout word and its valid strobe.
REQ-017 state  out  3  FSM state encoding: IDLE=0, ARMED=1, POST=2, DONE=3, READ=4.
REQ-018 count  out  TB_AW+1  number of valid words held in the trace RAM.

Function
REQ-019 FSM: IDLE -arm-> ARMED; ARMED -trigger-> POST; POST -(POST_LEN writes done)-> DONE; DONE -rd_next-> READ; READ -(last word issued)-> IDLE.
REQ-020 arm outside IDLE, and trigger outside ARMED, SHALL be ignored.
REQ-021 On arm, wr_addr and count SHALL clear to 0 in the same edge the state enters ARMED.
REQ-022 In ARMED and POST only, round-robin arbitration SHALL grant at most one asserted req per cycle; gnt=0 in all other states and when req=0.
REQ-023 Round-robin pointer SHALL advance to (granted index + 1) mod NREQ after each grant; with all req asserted, grants rotate 0,1,..,NREQ-1,0.
REQ-024 Grant-to-write latency SHALL be 1 cycle: tb_wr=1 with registered tb_din=granted word and tb_wr_addr=wr_addr; wr_addr then increments mod DEPTH.
REQ-025 count SHALL increment per write and saturate at DEPTH; in ARMED, writes beyond DEPTH overwrite oldest data (circular pre-trigger history).
REQ-026 Trigger and grant in the same ARMED cycle: that word SHALL count as pre-trigger; the post counter starts from 0 on the next grant.
REQ-027 POST SHALL exit after exactly POST_LEN granted words; the pipelined last write completes in the first DONE cycle; no grants in DONE.
REQ-028 On entering READ, rd_addr SHALL be (wr_addr - count) mod DEPTH (oldest word); a remaining counter loads count.
REQ-029 Each rd_next in DONE or READ with remaining>0 SHALL pulse tb_rd for 1 cycle at rd_addr, then increment rd_addr mod DEPTH and decrement remaining.
REQ-030 rd_valid SHALL pulse and rd_data SHALL equal tb_dout exactly 1 cycle after each tb_rd; rd_data holds otherwise.
REQ-031 When the read of the last word is issued, state SHALL return to IDLE; its rd_valid still appears next cycle; count clears to 0 on that transition.
REQ-032 rd_next in IDLE, ARMED or POST SHALL be ignored.
REQ-033 count=0 in DONE (possible only if unreachable; guard): rd_next SHALL return to IDLE with no tb_rd.

Reset
REQ-034 reset SHALL asynchronously force state=IDLE, gnt=0, tb_wr=0, tb_rd=0, rd_valid=0, tb_din=0, rd_data=0, wr_addr=0, rd_addr=0, count=0, rr pointer=0, post counter=0.
REQ-035 reset mid-capture or mid-readout SHALL abort without any further tb_wr or tb_rd; captured data is discarded.

Verification
V-1 arm; req=4'b1111 for 8 cycles; trigger; POST_LEN=4 -> gnt order 0,1,2,3,0,1,2,3,0,1,2,3; tb_wr 1 cycle after each gnt; DONE after 12 writes; count=12.
V-2 DEPTH=16, POST_LEN=4, 40 single-requester words before trigger -> count=16; readout returns the last 16 words written, oldest first, rd_valid 1 cycle after each rd_next.
V-3 trigger coincident with grant of word W -> W is pre-trigger; exactly POST_LEN further words written; no gnt in DONE.
V-4 arm asserted in POST; trigger in IDLE; rd_next in ARMED -> no state change, no tb_rd.
V-5 reset pulse during POST with req active -> gnt, tb_wr drop immediately; state=IDLE, count=0; next arm restarts at wr_addr 0.
V-6 read all count words via back-to-back rd_next -> last rd_valid one cycle after IDLE entry; extra rd_next in IDLE produces no tb_rd.
